instr_decode_pipe: RTL and testbench

//  Pipelined, parametrised successor to the single-register instruction decoder of the 8-bit core.
//  - Buffers fetched words in a prefetch queue of QDEPTH entries, with a valid/ready handshake.
//  - Loads the instruction register (IR) from the queue and decodes it into register enables, source select, ALU x/y selects, i_sel and jump flags.
//  - Inserts DM_WAIT stall cycles whenever data memory (dm) is a move source.
//  - Supports a PC-driven flush on taken jumps.

---
 rtl/instr_decode_pipe_if.sv | 11 +
 rtl/instr_decode_pipe.sv | 169 ++++++++++++++++
 tb/tb_instr_decode_pipe.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_pipe_if.sv
// rtl/instr_decode_pipe_if.sv - fetch-to-decoder word handshake
interface instr_decode_pipe_if #(
  parameter int IW = 8
);
  logic [IW-1:0] instr_in;
  logic          instr_valid;
  logic          instr_ready;

  modport master (output instr_in, output instr_valid, input instr_ready);
  modport slave  (input instr_in, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_decode_pipe.sv
// rtl/instr_decode_pipe.sv - prefetch queue, instruction register and decoder with dm wait stalls
module instr_decode_pipe #(
  parameter int IW      = 8,
  parameter int QDEPTH  = 4,
  parameter int DM_WAIT = 1
) (
  input  logic                         clk,
  input  logic                         async_reset_n,
  instr_decode_pipe_if.slave           fetch,
  input  logic                         flush,
  output logic [IW-1:0]                ir,
  output logic                         ir_valid,
  output logic [IW-5:0]                ir_imm,
  output logic [3:0]                   source_sel,
  output logic [8:0]                   reg_en,
  output logic                         i_sel,
  output logic                         x_sel,
  output logic                         y_sel,
  output logic                         jmp,
  output logic                         jmp_nz,
  output logic                         stall,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);
  localparam logic [CW-1:0] FULL      = CW'(QDEPTH);
  localparam logic [2:0]    WAIT_LOAD = 3'(DM_WAIT);

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [IW-1:0] mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    wait_cnt;
  logic          push;
  logic          pop;
  logic [IW-1:0] head;
  logic [7:0]    head_op;
  logic          head_dm_move;
  logic [7:0]    op;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  assign fetch.instr_ready = rst_n && !flush && (count != FULL);
  assign push    = fetch.instr_valid && fetch.instr_ready;
  assign stall   = (wait_cnt != 3'd0);
  assign pop     = !flush && !stall && (count != '0);
  assign head    = mem[rd_ptr];
  assign head_op = head[IW-1 -: 8];
  assign head_dm_move = (head_op[7:6] == 2'b10) && (head_op[2:0] == 3'd7) &&
                        (head_op[5:3] != 3'd7);
  assign q_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= fetch.instr_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
      wait_cnt <= 3'd0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ir_valid <= 1'b0;
      wait_cnt <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A stalled IR stays put; otherwise the IR tracks the queue head each cycle.
      if (stall) begin
        wait_cnt <= wait_cnt - 3'd1;
      end else if (count != '0) begin
        ir       <= head;
        ir_valid <= 1'b1;
        wait_cnt <= head_dm_move ? WAIT_LOAD : 3'd0;
      end else begin
        ir_valid <= 1'b0;
      end
    end
  end

  function automatic logic [8:0] dst_enable(input logic [2:0] dst);
    case (dst)
      3'd0:    return 9'h001;
      3'd1:    return 9'h002;
      3'd2:    return 9'h004;
      3'd3:    return 9'h008;
      3'd4:    return 9'h100;
      3'd5:    return 9'h020;
      3'd6:    return 9'h040;
      default: return 9'h0C0;
    endcase
  endfunction

  assign op     = ir[IW-1 -: 8];
  assign ir_imm = ir[IW-5:0];

  always_comb begin
    reg_en     = 9'h000;
    source_sel = 4'd10;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    jmp        = 1'b0;
    jmp_nz     = 1'b0;
    if (ir_valid) begin
      i_sel = 1'b1;
      if (!op[7]) begin
        reg_en     = dst_enable(op[6:4]);
        source_sel = 4'd8;
        i_sel      = (op[6:4] != 3'd6);
      end else if (!op[6]) begin
        reg_en = dst_enable(op[5:3]);
        if (op[2:0] == 3'd7) begin
          reg_en[6] = 1'b1;
        end
        // Moving a register onto itself selects the input pins, except for o_reg.
        if (op[2:0] != op[5:3]) begin
          source_sel = {1'b0, op[2:0]};
        end else if (op[5:3] == 3'd4) begin
          source_sel = 4'd4;
        end else begin
          source_sel = 4'd9;
        end
        i_sel = (op[5:3] != 3'd6);
      end else if (!op[5]) begin
        reg_en = 9'h010;
        x_sel  = op[4];
        y_sel  = op[3];
      end else if (!op[4]) begin
        jmp = 1'b1;
      end else begin
        jmp_nz = 1'b1;
      end
      if (stall) begin
        reg_en = 9'h000;
      end
    end
  end

endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb/tb_instr_decode_pipe.sv - scoreboard bench for instr_decode_pipe
module tb_instr_decode_pipe;
  localparam int IW      = 8;
  localparam int QDEPTH  = 4;
  localparam int DM_WAIT = 2;

  logic          clk = 1'b0;
  logic          async_reset_n;
  logic          flush;
  logic [IW-1:0] ir;
  logic          ir_valid;
  logic [IW-5:0] ir_imm;
  logic [3:0]    source_sel;
  logic [8:0]    reg_en;
  logic          i_sel, x_sel, y_sel, jmp, jmp_nz, stall;
  logic [2:0]    q_count;

  always #5 clk = ~clk;

  instr_decode_pipe_if #(.IW(IW)) fetch ();

  instr_decode_pipe #(.IW(IW), .QDEPTH(QDEPTH), .DM_WAIT(DM_WAIT)) dut (
    .clk(clk), .async_reset_n(async_reset_n), .fetch(fetch), .flush(flush),
    .ir(ir), .ir_valid(ir_valid), .ir_imm(ir_imm), .source_sel(source_sel),
    .reg_en(reg_en), .i_sel(i_sel), .x_sel(x_sel), .y_sel(y_sel),
    .jmp(jmp), .jmp_nz(jmp_nz), .stall(stall), .q_count(q_count)
  );

  typedef struct {
    logic [7:0] word;
    logic [8:0] reg_en;
    logic [3:0] src;
    logic       i_sel, x_sel, y_sel, jmp, jmp_nz;
    int         wait_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 0;
  int   stall_run = 0;
  int   reg_bit [8] = '{0, 1, 2, 3, 8, 5, 6, 7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t model(input logic [7:0] w);
    exp_t r;
    int dst, src;
    r.word = w; r.reg_en = '0; r.src = 4'd10; r.i_sel = 1'b1;
    r.x_sel = 1'b0; r.y_sel = 1'b0; r.jmp = 1'b0; r.jmp_nz = 1'b0; r.wait_cyc = 0;
    if (w < 8'h80) begin
      dst = int'(w[6:4]);
      r.reg_en = 9'(1 << reg_bit[dst]);
      if (dst == 7) r.reg_en = r.reg_en | 9'h040;
      r.src = 4'd8;
      r.i_sel = (dst != 6);
    end else if (w < 8'hC0) begin
      dst = int'(w[5:3]);
      src = int'(w[2:0]);
      r.reg_en = 9'(1 << reg_bit[dst]);
      if (dst == 7 || src == 7) r.reg_en = r.reg_en | 9'h040;
      if (src != dst) r.src = 4'(src);
      else r.src = (dst == 4) ? 4'd4 : 4'd9;
      r.i_sel = (dst != 6);
      if (src == 7 && dst != 7) r.wait_cyc = DM_WAIT;
    end else if (w < 8'hE0) begin
      r.reg_en = 9'h010;
      r.x_sel = w[4];
      r.y_sel = w[3];
    end else if (w < 8'hF0) begin
      r.jmp = 1'b1;
    end else begin
      r.jmp_nz = 1'b1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready_rule", 32'(fetch.instr_ready), 32'((q_count < QDEPTH) && !flush));
      if (!ir_valid) begin
        stall_run = 0;
        chk("idle_reg_en", 32'(reg_en), 32'h0);
        chk("idle_source_sel", 32'(source_sel), 32'd10);
        chk("idle_stall", 32'(stall), 32'h0);
      end else if (stall) begin
        stall_run++;
        chk("stall_reg_en", 32'(reg_en), 32'h0);
      end else if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ir: got %0h, expected no live instruction", ir);
      end else begin
        e = exp_q.pop_front();
        chk("ir", 32'(ir), 32'(e.word));
        chk("ir_imm", 32'(ir_imm), 32'(e.word[3:0]));
        chk("reg_en", 32'(reg_en), 32'(e.reg_en));
        chk("source_sel", 32'(source_sel), 32'(e.src));
        chk("i_sel", 32'(i_sel), 32'(e.i_sel));
        chk("xy_sel", 32'({x_sel, y_sel}), 32'({e.x_sel, e.y_sel}));
        chk("jmp", 32'({jmp, jmp_nz}), 32'({e.jmp, e.jmp_nz}));
        chk("wait_cycles", 32'(stall_run), 32'(e.wait_cyc));
        stall_run = 0;
      end
    end
  end

  task automatic cyc(input bit v, input logic [7:0] w, input bit fl);
    bit rdy;
    fetch.instr_valid = v;
    fetch.instr_in    = w;
    flush             = fl;
    @(negedge clk);
    rdy = fetch.instr_ready;
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (v && rdy) exp_q.push_back(model(w));
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ir_valid) && n < 60) begin
      cyc(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dir [8] = '{8'h2A, 8'h9B, 8'hA4, 8'hD8, 8'hE3, 8'hF3, 8'h87, 8'h01};
    logic [7:0] w;
    bit full_seen;
    int n;

    async_reset_n = 1'b1;
    flush = 1'b0;
    fetch.instr_valid = 1'b0;
    fetch.instr_in = '0;
    #2 async_reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_q_count", 32'(q_count), 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_reg_en", 32'(reg_en), 32'h0);
    chk("rst_source_sel", 32'(source_sel), 32'd10);
    chk("rst_stall", 32'(stall), 32'h0);
    async_reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 mon_en = 1;

    // Minimum latency: pushed at one edge, in IR at the next, never earlier.
    cyc(1'b1, 8'h2A, 1'b0);
    fetch.instr_valid = 1'b0;
    @(negedge clk);
    chk("no_bypass", 32'(ir_valid), 32'h0);
    @(negedge clk);
    chk("lat_ir", 32'(ir), 32'h2A);
    chk("lat_reg_en", 32'(reg_en), 32'h004);
    chk("lat_source_sel", 32'(source_sel), 32'd8);
    chk("lat_ir_imm", 32'(ir_imm), 32'hA);
    @(posedge clk); #1;
    drain();

    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    drain();

    foreach (dir[i]) cyc(1'b1, dir[i], 1'b0);
    drain();

    cyc(1'b1, 8'h87, 1'b0);
    cyc(1'b1, 8'h01, 1'b0);
    fetch.instr_valid = 1'b0;
    @(negedge clk);
    chk("dm_stall1", 32'({stall, ir}), 32'h187);
    chk("dm_stall1_reg_en", 32'(reg_en), 32'h0);
    @(negedge clk);
    chk("dm_stall2", 32'(stall), 32'h1);
    @(negedge clk);
    chk("dm_release_stall", 32'(stall), 32'h0);
    chk("dm_release_reg_en", 32'(reg_en), 32'h041);
    chk("dm_release_i_sel", 32'(i_sel), 32'h1);
    @(negedge clk);
    chk("dm_next_ir", 32'({ir_valid, ir}), 32'h101);
    @(posedge clk); #1;
    drain();

    // Chained dm moves hold the IR long enough for the queue to fill.
    full_seen = 0;
    for (int i = 0; i < 40 && !full_seen; i++) begin
      if (q_count == 3'(QDEPTH)) begin
        full_seen = 1;
        chk("full_ready", 32'(fetch.instr_ready), 32'h0);
        cyc(1'b1, 8'h55, 1'b0);
      end else begin
        cyc(1'b1, 8'h8F, 1'b0);
      end
    end
    chk("full_reached", 32'(full_seen), 32'h1);
    drain();

    cyc(1'b1, 8'h87, 1'b0);
    n = 0;
    while (q_count != 3'd3 && n < 10) begin
      cyc(1'b1, 8'h01, 1'b0);
      n++;
    end
    chk("flush_pre_count", 32'(q_count), 32'h3);
    cyc(1'b1, 8'h22, 1'b1);
    chk("flush_q_count", 32'(q_count), 32'h0);
    chk("flush_ir_valid", 32'(ir_valid), 32'h0);
    drain();

    for (int i = 0; i < 400; i++) begin
      w = 8'($urandom);
      if ($urandom_range(0, 3) == 0) w = {2'b10, (w[5:3] == 3'd7) ? 3'd0 : w[5:3], 3'd7};
      cyc($urandom_range(0, 9) < 7, w, $urandom_range(0, 39) == 0);
    end
    drain();

    cyc(1'b1, 8'h87, 1'b0);
    cyc(1'b1, 8'h01, 1'b0);
    mon_en = 0;
    #2 async_reset_n = 1'b0;
    #1;
    chk("arst_q_count", 32'(q_count), 32'h0);
    chk("arst_ir_valid", 32'(ir_valid), 32'h0);
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_reg_en", 32'(reg_en), 32'h0);
    exp_q.delete();
    fetch.instr_valid = 1'b0;
    @(negedge clk);
    async_reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 mon_en = 1;
    cyc(1'b1, 8'hC8, 1'b0);
    cyc(1'b1, 8'h6C, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
